camera_queue_writer: RTL and testbench
======================================

// Module: camera_queue_writer
// PURPOSE
// Producer end of the 17-bit pixel queue drained by the LCD controller.
// Captures OV7670 RGB565 bytes and crops to the LCD window. Writes a framed
// stream: FRAME_START, then per row ROW_START + exactly LCD_SCREEN_WIDTH
// pixels, then FRAME_END. Sits between the camera sync logic and the queue write port.
// PARAMETERS
// LCD_SCREEN_WIDTH   480  pixels written per row (crop or pad target)
// LCD_SCREEN_HEIGHT  272  max rows per frame; camera rows beyond are ignored
// PORTS
// clk             in   1   system clock; also queue write clock
// reset_n         in   1   async active-low reset
// cam_vsync       in   1   camera VSYNC, synchronous to clk; high = vertical blank
// cam_href        in   1   camera HREF, synchronous to clk; high = active row
// cam_sample      in   1   1-cycle strobe: cam_data valid this cycle
// cam_data        in   8   camera byte, first byte of a pixel first
// queue_full      in   1   queue cannot accept a write this cycle
// queue_wr_en     out  1   write strobe, 1 word per asserted cycle
// queue_data_out  out  17  word written when queue_wr_en=1
// overflow        out  1   sticky: pixel dropped this frame
// drop_count      out  16  pixels dropped this frame, saturating
// BEHAVIOUR
// Word format:
// - pixels {1'b0, R5, G6, B5}
// - markers FRAME_START=17'h10000, ROW_START=17'h10001, FRAME_END=17'h1FFFF
// Pixel assembly:
// - byte0 -> {R5,G6[5:3]}, byte1 -> {G6[2:0],B5}
// - byte phase clears on cam_href rising edge
// - pixel valid 1 cycle after byte1 sample
// Reset (async, immediate) outputs:
// - queue_wr_en=0, queue_data_out=0, overflow=0, drop_count=0
// - state=IDLE, counters=0
// Never writes while queue_full=1. Registered outputs, one write max per cycle.
// States (edges detected against previous-cycle registered copies):
// - IDLE: wait cam_vsync=1 -> WAIT_FRAME. A reset mid-frame therefore
//   restarts only at the next full frame; no marker is emitted by reset.
// - WAIT_FRAME: on vsync falling edge, queue FRAME_START, clear row_cnt,
//   overflow and drop_count -> WAIT_ROW.
// - WAIT_ROW:
//   - href rise with row_cnt<HEIGHT: queue ROW_START, col_cnt=0 -> CAPTURE_ROW.
//   - href rise with row_cnt>=HEIGHT: row is ignored.
//   - vsync rise: queue FRAME_END -> WAIT_FRAME.
// - CAPTURE_ROW:
//   - each assembled pixel with col_cnt<WIDTH: write, col_cnt++.
//   - pixels with col_cnt>=WIDTH are cropped (not counted as drops).
//   - on href fall: row_cnt++ -> PAD_ROW.
// - PAD_ROW: write 17'h00000 each non-full cycle until col_cnt==WIDTH -> WAIT_ROW.
//   - href rise while PAD_ROW: that camera row is skipped entirely.
//   - vsync rise while PAD_ROW: finish padding first, then FRAME_END.
// Markers:
// - Marker writes go through a 1-entry pending register.
// - A marker blocked by queue_full is held and issued the first non-full cycle.
// - Markers have priority over pixels.
// Drops:
// - A pixel blocked by queue_full or a pending marker is dropped.
// - A drop sets overflow and increments drop_count (saturates at FFFF).
// - col_cnt counts written pixels only, so PAD_ROW always restores exact row
//   length. Every ROW_START is followed by exactly WIDTH pixel words.
// Simultaneous events in one cycle:
// - pixel assembled and href fall: pixel handled first.
// - vsync rise and href rise: vsync wins, the row is ignored.
// Width/counters: col_cnt, row_cnt 11 bit; compares use parameters.
// STRUCTURE
// Package CameraQueueWriterTypes: t_state enum (IDLE, WAIT_FRAME, WAIT_ROW,
// CAPTURE_ROW, PAD_ROW) and marker localparams FRAME_START/ROW_START/FRAME_END.
// The LCD controller imports the same marker constants.
// Sub-module rgb565_byte_pair: byte phase + 16-bit pixel register + pixel_valid.
// TESTING
// 1. WIDTH=8, HEIGHT=4; 4 rows x 8 px, queue never full -> 10000, then 4x(10001 + 8 px), then 1FFFF. 38 words, overflow=0.
// 2. Row of 12 px at WIDTH=8 -> 8 px written, 4 cropped, drop_count=0.
// 3. Row of 5 px -> 5 px + 3 words 00000, then next ROW_START.
// 4. queue_full high 3 cycles at a ROW_START -> marker held, issued when full falls; pixels in the window dropped; row padded to 8; drop_count equals dropped count.
// 5. 6 camera rows at HEIGHT=4 -> exactly 4 ROW_START, FRAME_END on vsync rise.
// 6. reset_n low mid-row -> outputs 0 immediately; no words until vsync high then falling; then 10000.

Source files
------------

// File: rtl/camera_queue_writer_pkg.sv
// Shared types and queue word constants for the camera -> LCD pixel queue.
// The LCD controller imports the same marker constants so both ends agree on framing.
package CameraQueueWriterTypes;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_ROW,
        CAPTURE_ROW,
        PAD_ROW
    } t_state;

    // Bit 16 set marks a control word; pixels always have bit 16 clear.
    localparam logic [16:0] FRAME_START = 17'h10000;
    localparam logic [16:0] ROW_START   = 17'h10001;
    localparam logic [16:0] FRAME_END   = 17'h1FFFF;
    localparam logic [16:0] PAD_WORD    = 17'h00000;

    function automatic logic [16:0] pixel_word(input logic [15:0] rgb565);
        return {1'b0, rgb565};
    endfunction

endpackage

// File: rtl/camera_queue_writer_byte_pair.sv
// Assembles two OV7670 bytes into one RGB565 pixel.
// byte0 = {R5, G6[5:3]}, byte1 = {G6[2:0], B5}; pixel_valid pulses the cycle after byte1.
module rgb565_byte_pair (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        href,
    input  logic        href_rise,
    input  logic        sample,
    input  logic [7:0]  data,
    output logic        pixel_valid,
    output logic [15:0] pixel
);

    logic       phase;
    logic [7:0] hi_byte;
    logic       phase_eff;

    // A row start realigns the pair even if the previous row ended on an odd byte.
    assign phase_eff = phase & ~href_rise;

    // Byte phase tracking and pixel register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= 1'b0;
            hi_byte     <= 8'h00;
            pixel       <= 16'h0000;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (href_rise) phase <= 1'b0;
            if (sample && href) begin
                if (!phase_eff) begin
                    hi_byte <= data;
                    phase   <= 1'b1;
                end else begin
                    pixel       <= {hi_byte, data};
                    pixel_valid <= 1'b1;
                    phase       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/camera_queue_writer.sv
// Producer end of the 17-bit pixel queue feeding the LCD controller.
// Crops/pads camera rows to the LCD window and frames the stream with markers.
module camera_queue_writer #(
    parameter int LCD_SCREEN_WIDTH  = 480,
    parameter int LCD_SCREEN_HEIGHT = 272
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_sample,
    input  logic [7:0]  cam_data,
    input  logic        queue_full,
    output logic        queue_wr_en,
    output logic [16:0] queue_data_out,
    output logic        overflow,
    output logic [15:0] drop_count
);
    import CameraQueueWriterTypes::*;

    localparam logic [10:0] WIDTH_C  = 11'(LCD_SCREEN_WIDTH);
    localparam logic [10:0] HEIGHT_C = 11'(LCD_SCREEN_HEIGHT);

    t_state      state;
    logic        vsync_q, href_q;
    logic        vsync_rise, vsync_fall, href_rise, href_fall;
    logic [10:0] col_cnt, row_cnt;
    logic        pend;
    logic [16:0] pend_word;
    logic        frame_end_req;
    logic        pixel_valid;
    logic [15:0] pixel;
    logic        mk_issue, slot_free;

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign vsync_fall = ~cam_vsync & vsync_q;
    assign href_rise  = cam_href & ~href_q;
    assign href_fall  = ~cam_href & href_q;

    // A pending marker owns the write slot; data words only go out when no marker waits.
    assign mk_issue  = pend & ~queue_full;
    assign slot_free = ~pend & ~queue_full;

    rgb565_byte_pair u_byte_pair (
        .clk         (clk),
        .reset_n     (reset_n),
        .href        (cam_href),
        .href_rise   (href_rise),
        .sample      (cam_sample),
        .data        (cam_data),
        .pixel_valid (pixel_valid),
        .pixel       (pixel)
    );

    // Framing FSM, marker holding register and registered queue write port.
    // Markers are spaced by whole rows, so a new marker never lands on a blocked one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            col_cnt        <= 11'd0;
            row_cnt        <= 11'd0;
            pend           <= 1'b0;
            pend_word      <= PAD_WORD;
            frame_end_req  <= 1'b0;
            queue_wr_en    <= 1'b0;
            queue_data_out <= PAD_WORD;
            overflow       <= 1'b0;
            drop_count     <= 16'h0000;
        end else begin
            vsync_q     <= cam_vsync;
            href_q      <= cam_href;
            queue_wr_en <= 1'b0;

            if (mk_issue) begin
                queue_wr_en    <= 1'b1;
                queue_data_out <= pend_word;
                pend           <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cam_vsync) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        pend          <= 1'b1;
                        pend_word     <= FRAME_START;
                        row_cnt       <= 11'd0;
                        overflow      <= 1'b0;
                        drop_count    <= 16'h0000;
                        frame_end_req <= 1'b0;
                        state         <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    // vsync beats a coincident href rise; rows past the window are ignored.
                    if (vsync_rise) begin
                        pend      <= 1'b1;
                        pend_word <= FRAME_END;
                        state     <= WAIT_FRAME;
                    end else if (href_rise && (row_cnt < HEIGHT_C)) begin
                        pend      <= 1'b1;
                        pend_word <= ROW_START;
                        col_cnt   <= 11'd0;
                        state     <= CAPTURE_ROW;
                    end
                end
                CAPTURE_ROW: begin
                    if (vsync_rise) frame_end_req <= 1'b1;
                    // Pixels beyond the window are cropped silently; blocked ones are drops.
                    if (pixel_valid && (col_cnt < WIDTH_C)) begin
                        if (slot_free) begin
                            queue_wr_en    <= 1'b1;
                            queue_data_out <= pixel_word(pixel);
                            col_cnt        <= col_cnt + 11'd1;
                        end else begin
                            overflow <= 1'b1;
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        end
                    end
                    if (href_fall) begin
                        row_cnt <= row_cnt + 11'd1;
                        state   <= PAD_ROW;
                    end
                end
                PAD_ROW: begin
                    if (vsync_rise) frame_end_req <= 1'b1;
                    if (col_cnt == WIDTH_C) begin
                        if (frame_end_req || vsync_rise) begin
                            pend          <= 1'b1;
                            pend_word     <= FRAME_END;
                            frame_end_req <= 1'b0;
                            state         <= WAIT_FRAME;
                        end else begin
                            state <= WAIT_ROW;
                        end
                    end else if (slot_free) begin
                        queue_wr_en    <= 1'b1;
                        queue_data_out <= PAD_WORD;
                        col_cnt        <= col_cnt + 11'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_queue_writer.sv
// Directed + randomized bench for camera_queue_writer at an 8x4 LCD window.
module tb_camera_queue_writer;
    import CameraQueueWriterTypes::*;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_vsync = 1'b0, cam_href = 1'b0, cam_sample = 1'b0, queue_full = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        queue_wr_en;
    logic [16:0] queue_data_out;
    logic        overflow;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    camera_queue_writer #(.LCD_SCREEN_WIDTH(W), .LCD_SCREEN_HEIGHT(H)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_sample     (cam_sample),
        .cam_data       (cam_data),
        .queue_full     (queue_full),
        .queue_wr_en    (queue_wr_en),
        .queue_data_out (queue_data_out),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Capture every queue write; flag any write decided while full was asserted.
    logic        full_at_edge = 1'b0;
    logic [16:0] got_mem [0:4095];
    int          wr_cnt = 0;
    int          viol = 0;

    always @(posedge clk) full_at_edge = queue_full;

    always @(negedge clk) begin
        if (queue_wr_en === 1'b1) begin
            if (wr_cnt < 4096) got_mem[wr_cnt] = queue_data_out;
            wr_cnt++;
            if (full_at_edge) viol++;
        end
    end

    // Reference model state: expected words, frame bookkeeping.
    logic [16:0] exp_q [$];
    logic [15:0] row_px [$];
    int          rd = 0;
    bit          in_frame = 1'b0;
    int          rows_done = 0;
    int          frame_drops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Row outcome from the rules: ROW_START, then pixels in order unless full or
    // still behind the marker, cropped once W are written, zero-padded to W.
    task automatic model_row(input logic [31:0] fmask);
        int issue, col, e;
        bit f;
        if (!in_frame || rows_done >= H) return;
        exp_q.push_back(ROW_START);
        issue = 1;
        while (issue < 32 && fmask[issue]) issue++;
        col = 0;
        for (int j = 0; j < row_px.size(); j++) begin
            e = 4 + 4 * j;
            f = (e < 32) ? fmask[e] : 1'b0;
            if (col >= W) continue;
            if (e <= issue || f) frame_drops++;
            else begin
                exp_q.push_back({1'b0, row_px[j]});
                col++;
            end
        end
        while (col < W) begin
            exp_q.push_back(17'h00000);
            col++;
        end
        rows_done++;
    endtask

    // One camera row: href at cycle 0, byte i sampled at cycle 1+2i, then a quiet gap.
    task automatic cam_row(input int n, input logic [31:0] fmask_in, input int rst_at);
        logic [31:0] fmask;
        int cyc, i, j;
        row_px.delete();
        for (int p = 0; p < n; p++) row_px.push_back(16'($urandom) | 16'h0001);
        fmask = 32'h0;
        for (int b = 0; b < 32; b++) if (b < 4 * n) fmask[b] = fmask_in[b];
        model_row(fmask);
        cyc = 4 * n + W + 6;
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            cam_href   = (k < 4 * n);
            cam_sample = (k < 4 * n) && (k % 2 == 1);
            i = (k - 1) / 2;
            j = i / 2;
            if (cam_sample) cam_data = (i % 2 == 0) ? row_px[j][15:8] : row_px[j][7:0];
            else            cam_data = 8'($urandom);
            queue_full = (k < 32) ? fmask[k] : 1'b0;
            if (k == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst wr_en", 32'(queue_wr_en), 32'd0);
                check("rst data", 32'(queue_data_out), 32'd0);
                check("rst overflow", 32'(overflow), 32'd0);
                check("rst drop_count", 32'(drop_count), 32'd0);
            end
            if (rst_at >= 0 && k == rst_at + 2) reset_n = 1'b1;
        end
        cam_sample = 1'b0;
        queue_full = 1'b0;
    endtask

    task automatic vs_high();
        repeat (3) begin
            @(negedge clk);
            cam_vsync = 1'b1; cam_href = 1'b0; cam_sample = 1'b0; queue_full = 1'b0;
        end
        if (in_frame) exp_q.push_back(FRAME_END);
        in_frame = 1'b0;
    endtask

    task automatic vs_low();
        repeat (3) begin
            @(negedge clk);
            cam_vsync = 1'b0;
        end
        exp_q.push_back(FRAME_START);
        in_frame    = 1'b1;
        rows_done   = 0;
        frame_drops = 0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Compare captured words and drop status with the model, then consume both.
    task automatic checkpoint(input string tag);
        int ngot, nmis;
        settle();
        ngot = wr_cnt - rd;
        nmis = 0;
        check({tag, " word count"}, 32'(ngot), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < ngot && got_mem[rd + i] !== exp_q[i]) nmis++;
        check({tag, " word mismatches"}, 32'(nmis), 32'd0);
        check({tag, " drop_count"}, 32'(drop_count), 32'(frame_drops));
        check({tag, " overflow"}, 32'(overflow), 32'(frame_drops > 0));
        rd = wr_cnt;
        exp_q.delete();
    endtask

    initial begin
        int rsc, nrows;

        // Reset state
        #12;
        check("reset wr_en", 32'(queue_wr_en), 32'd0);
        check("reset data", 32'(queue_data_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        vs_high();

        // 1: full 4x8 frame, queue never full
        vs_low();
        for (int r = 0; r < 4; r++) cam_row(8, 32'h0, -1);
        vs_high();
        settle();
        check("t1 total words", 32'(wr_cnt - rd), 32'd38);
        checkpoint("t1");

        // 2: 12-pixel row cropped to 8
        vs_low();
        cam_row(12, 32'h0, -1);
        vs_high();
        checkpoint("t2");

        // 3: short row padded, followed by a normal row
        vs_low();
        cam_row(5, 32'h0, -1);
        cam_row(8, 32'h0, -1);
        vs_high();
        checkpoint("t3");

        // 4: full for 3 cycles right after ROW_START
        vs_low();
        cam_row(8, 32'h0000_000E, -1);
        vs_high();
        settle();
        check("t4 drop_count", 32'(drop_count), 32'd1);
        checkpoint("t4");
        vs_low();
        cam_row(8, 32'h0000_01FE, -1);
        vs_high();
        settle();
        check("t4b drop_count", 32'(drop_count), 32'd2);
        checkpoint("t4b");

        // 5: 6 camera rows against a 4-row window
        vs_low();
        for (int r = 0; r < 6; r++) cam_row($urandom_range(1, 12), 32'h0, -1);
        vs_high();
        settle();
        rsc = 0;
        for (int i = rd; i < wr_cnt; i++) if (got_mem[i] == ROW_START) rsc++;
        check("t5 row_starts", 32'(rsc), 32'd4);
        checkpoint("t5");

        // 6: reset mid-row, then restart only on a full vsync pulse
        vs_low();
        cam_row(8, 32'h0000_000E, -1);
        checkpoint("t6 pre");
        in_frame = 1'b0;
        cam_row(8, 32'h0, 10);
        settle();
        rd = wr_cnt;
        frame_drops = 0;
        cam_row(6, 32'h0, -1);
        cam_row(8, 32'h0, -1);
        settle();
        check("t6 no words in idle", 32'(wr_cnt - rd), 32'd0);
        vs_high();
        settle();
        check("t6 no words on vsync high", 32'(wr_cnt - rd), 32'd0);
        vs_low();
        checkpoint("t6 restart");

        // Randomized frames with sparse queue_full
        for (int f = 0; f < 4; f++) begin
            vs_high();
            checkpoint("rand end");
            vs_low();
            nrows = $urandom_range(1, 6);
            for (int r = 0; r < nrows; r++)
                cam_row($urandom_range(1, 12), $urandom & $urandom & $urandom, -1);
        end
        vs_high();
        checkpoint("rand final");

        check("write while full", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
